fp_addsub: RTL and testbench

- Parametrised IEEE-754 floating-point adder/subtractor using the codebase's stb/ack handshake. Next generation of the single-precision adder.
- Adds field widths as parameters, a subtract mode, correct result sign, denormal inputs and outputs, and round-to-nearest-even using guard/round/sticky bits.
- Sits between operand sources and consumers in the matrix-multiplier datapath, typically as the accumulator behind the multiplier.

---
 rtl/fp_pkg.sv | 67 ++++++
 rtl/fp_round.sv | 34 +++
 rtl/fp_addsub.sv | 259 +++++++++++++++++++++++++
 tb/tb_fp_addsub.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the floating-point add/subtract datapath.
//   - state_t     : FSM state encoding for fp_addsub
//   - word_w      : total word width from exponent/fraction widths
//   - ext_man_w   : hidden bit + fraction + guard/round/sticky width
//   - work_exp_w  : working exponent width (headroom for carry and rounding)
//   - qnan_word   : canonical quiet NaN for a given format (LSB-aligned, 64 bits)
//   - is_nan/is_inf/is_zero : classifiers on a word zero-extended to 64 bits
package fp_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    GET_A   = 4'd0,
    GET_B   = 4'd1,
    UNPACK  = 4'd2,
    SPECIAL = 4'd3,
    ALIGN   = 4'd4,
    ADD     = 4'd5,
    NORM    = 4'd6,
    ROUND   = 4'd7,
    PACK    = 4'd8,
    PUT_Z   = 4'd9
  } state_t;

  localparam logic [63:0] ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic int word_w(input int exp_w, input int man_w);
    return exp_w + man_w + 32'sd1;
  endfunction

  function automatic int ext_man_w(input int man_w);
    return man_w + 32'sd4;
  endfunction

  function automatic int work_exp_w(input int exp_w);
    return exp_w + 32'sd2;
  endfunction

  function automatic logic [63:0] low_mask(input int n);
    return ~(ONES_64 << n);
  endfunction

  function automatic logic [63:0] exp_field(input logic [63:0] word, input int exp_w, input int man_w);
    return (word >> man_w) & low_mask(exp_w);
  endfunction

  function automatic logic [63:0] frac_field(input logic [63:0] word, input int man_w);
    return word & low_mask(man_w);
  endfunction

  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    return (low_mask(exp_w) << man_w) | (64'd1 << (man_w - 32'sd1));
  endfunction

  function automatic logic is_nan(input logic [63:0] word, input int exp_w, input int man_w);
    return (exp_field(word, exp_w, man_w) == low_mask(exp_w)) && (frac_field(word, man_w) != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] word, input int exp_w, input int man_w);
    return (exp_field(word, exp_w, man_w) == low_mask(exp_w)) && (frac_field(word, man_w) == 64'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] word, input int exp_w, input int man_w);
    return (exp_field(word, exp_w, man_w) == 64'd0) && (frac_field(word, man_w) == 64'd0);
  endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round: combinational round-to-nearest-even on guard/round/sticky.
//   norm_exp : working exponent of the normalised (or denormal) value
//   norm_man : {hidden, fraction, guard, round, sticky}
//   rnd_exp  : exponent after rounding (+1 on mantissa overflow)
//   rnd_man  : {hidden, fraction} after rounding
module fp_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+1:0] norm_exp,
  input  logic [MAN_W+3:0] norm_man,
  output logic [EXP_W+1:0] rnd_exp,
  output logic [MAN_W:0]   rnd_man
);

  logic             up_s;
  logic [MAN_W+1:0] inc_s;

  // Round up when above half, or exactly half with an odd LSB.
  always_comb begin
    up_s  = norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
    inc_s = {1'b0, norm_man[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, up_s};
    if (inc_s[MAN_W+1]) begin
      // 1.11..1 rounded up to 10.00..0: renormalise; a denormal rounding
      // into the hidden bit needs no action since its exponent is already 1
      rnd_man = inc_s[MAN_W+1:1];
      rnd_exp = norm_exp + (EXP_W+2)'(1);
    end else begin
      rnd_man = inc_s[MAN_W:0];
      rnd_exp = norm_exp;
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754 adder/subtractor with stb/ack handshakes.
//   clk, rst                    : clock, synchronous active-high reset
//   input_a / _stb / _ack       : operand A handshake
//   input_b, input_op / _stb / _ack : operand B and mode (0 add, 1 subtract)
//   output_z / _stb / _ack      : result handshake, held until consumed
module fp_addsub
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic         input_a_stb,
  output logic         input_a_ack,
  input  logic [W-1:0] input_b,
  input  logic         input_op,
  input  logic         input_b_stb,
  output logic         input_b_ack,
  output logic [W-1:0] output_z,
  output logic         output_z_stb,
  input  logic         output_z_ack
);

  localparam int XW = work_exp_w(EXP_W);
  localparam int MW = ext_man_w(MAN_W);
  localparam int SW = MW + 1;
  localparam logic [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [XW-1:0] EXP_ONES = XW'(low_mask(EXP_W));
  localparam logic [XW-1:0] SH_MAX   = XW'(MAN_W + 3);
  localparam logic [W-1:0]  QNAN     = W'(qnan_word(EXP_W, MAN_W));

  state_t          state_r;
  logic [W-1:0]    a_r, b_r, z_r;
  logic            op_r, a_sign_r, b_sign_r, z_sign_r, special_r;
  logic [XW-1:0]   a_exp_r, b_exp_r, z_exp_r;
  logic [MW-1:0]   a_man_r, b_man_r;
  logic [SW-1:0]   z_man_r;
  logic [MAN_W:0]  z_fin_r;

  logic            a_hid_s, b_hid_s, spec_hit_s, a_big_s, sum_sign_s, norm_done_s;
  logic            a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [XW-1:0]   a_uexp_s, b_uexp_s, diff_s, sh_s, norm_exp_s, rnd_exp_s;
  logic [MW-1:0]   a_uman_s, b_uman_s, small_man_s, shifted_s, aligned_s;
  logic [SW-1:0]   sum_s, norm_man_s;
  logic [MAN_W:0]  rnd_man_s;
  logic [W-1:0]    spec_z_s, pack_s;
  state_t          add_next_s;

  // Unpack: exponent field 0 is a denormal with effective exponent 1.
  always_comb begin
    a_hid_s  = (a_r[W-2:MAN_W] != {EXP_W{1'b0}});
    b_hid_s  = (b_r[W-2:MAN_W] != {EXP_W{1'b0}});
    a_uexp_s = a_hid_s ? XW'(a_r[W-2:MAN_W]) : EXP_ONE;
    b_uexp_s = b_hid_s ? XW'(b_r[W-2:MAN_W]) : EXP_ONE;
    a_uman_s = {a_hid_s, a_r[MAN_W-1:0], 3'b000};
    b_uman_s = {b_hid_s, b_r[MAN_W-1:0], 3'b000};
  end

  // Special-case detection on raw words with effective (post-op) signs.
  always_comb begin
    a_nan_s    = is_nan(64'(a_r), EXP_W, MAN_W);
    b_nan_s    = is_nan(64'(b_r), EXP_W, MAN_W);
    a_inf_s    = is_inf(64'(a_r), EXP_W, MAN_W);
    b_inf_s    = is_inf(64'(b_r), EXP_W, MAN_W);
    a_zero_s   = is_zero(64'(a_r), EXP_W, MAN_W);
    b_zero_s   = is_zero(64'(b_r), EXP_W, MAN_W);
    spec_hit_s = 1'b1;
    if (a_nan_s || b_nan_s) begin
      spec_z_s = QNAN;
    end else if (a_inf_s && b_inf_s && (a_sign_r != b_sign_r)) begin
      spec_z_s = QNAN;
    end else if (a_inf_s) begin
      spec_z_s = {a_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf_s) begin
      spec_z_s = {b_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero_s && b_zero_s) begin
      spec_z_s = {a_sign_r & b_sign_r, {(W-1){1'b0}}};
    end else begin
      spec_hit_s = 1'b0;
      spec_z_s   = {W{1'b0}};
    end
  end

  // Align: shift the smaller operand right, folding lost bits into sticky.
  always_comb begin
    a_big_s = (a_exp_r >= b_exp_r);
    if (a_big_s) begin
      diff_s      = a_exp_r - b_exp_r;
      small_man_s = b_man_r;
    end else begin
      diff_s      = b_exp_r - a_exp_r;
      small_man_s = a_man_r;
    end
    sh_s      = (diff_s > SH_MAX) ? SH_MAX : diff_s;
    shifted_s = small_man_s >> sh_s;
    aligned_s = {shifted_s[MW-1:1],
                 shifted_s[0] | (|(small_man_s & ~({MW{1'b1}} << sh_s)))};
  end

  // Magnitude add/subtract and the choice of whether NORM has work to do.
  always_comb begin
    if (a_sign_r == b_sign_r) begin
      sum_s      = {1'b0, a_man_r} + {1'b0, b_man_r};
      sum_sign_s = a_sign_r;
    end else if (a_man_r >= b_man_r) begin
      sum_s      = {1'b0, a_man_r} - {1'b0, b_man_r};
      sum_sign_s = a_sign_r & (a_man_r != b_man_r);  // exact zero is +0
    end else begin
      sum_s      = {1'b0, b_man_r} - {1'b0, a_man_r};
      sum_sign_s = b_sign_r;
    end
    if (sum_s == {SW{1'b0}}) begin
      add_next_s = ROUND;
    end else if (sum_s[SW-1]) begin
      add_next_s = NORM;
    end else if (!sum_s[SW-2] && (a_exp_r > EXP_ONE)) begin
      add_next_s = NORM;
    end else begin
      add_next_s = ROUND;
    end
  end

  // One normalisation step; done flag looks at the post-step value.
  always_comb begin
    if (z_man_r[SW-1]) begin
      norm_man_s  = {1'b0, z_man_r[SW-1:2], z_man_r[1] | z_man_r[0]};
      norm_exp_s  = z_exp_r + EXP_ONE;
      norm_done_s = 1'b1;
    end else begin
      norm_man_s  = z_man_r << 1;
      norm_exp_s  = z_exp_r - EXP_ONE;
      norm_done_s = norm_man_s[SW-2] || (norm_exp_s == EXP_ONE);
    end
  end

  fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .norm_exp (z_exp_r),
    .norm_man (z_man_r[MW-1:0]),
    .rnd_exp  (rnd_exp_s),
    .rnd_man  (rnd_man_s)
  );

  // Pack: overflow saturates to inf; missing hidden bit means denormal.
  always_comb begin
    if (z_exp_r >= EXP_ONES) begin
      pack_s = {z_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (!z_fin_r[MAN_W]) begin
      pack_s = {z_sign_r, {EXP_W{1'b0}}, z_fin_r[MAN_W-1:0]};
    end else begin
      pack_s = {z_sign_r, z_exp_r[EXP_W-1:0], z_fin_r[MAN_W-1:0]};
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= {W{1'b0}};
      a_r <= {W{1'b0}};  b_r <= {W{1'b0}};  z_r <= {W{1'b0}};
      op_r <= 1'b0;  a_sign_r <= 1'b0;  b_sign_r <= 1'b0;
      z_sign_r <= 1'b0;  special_r <= 1'b0;
      a_exp_r <= {XW{1'b0}};  b_exp_r <= {XW{1'b0}};  z_exp_r <= {XW{1'b0}};
      a_man_r <= {MW{1'b0}};  b_man_r <= {MW{1'b0}};
      z_man_r <= {SW{1'b0}};  z_fin_r <= {(MAN_W+1){1'b0}};
    end else begin
      case (state_r)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_r         <= input_a;
            input_a_ack <= 1'b0;
            state_r     <= GET_B;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        GET_B: begin
          if (input_b_ack && input_b_stb) begin
            b_r         <= input_b;
            op_r        <= input_op;
            input_b_ack <= 1'b0;
            state_r     <= UNPACK;
          end else begin
            input_b_ack <= 1'b1;
          end
        end
        UNPACK: begin
          a_sign_r  <= a_r[W-1];
          b_sign_r  <= b_r[W-1] ^ op_r;
          a_exp_r   <= a_uexp_s;
          b_exp_r   <= b_uexp_s;
          a_man_r   <= a_uman_s;
          b_man_r   <= b_uman_s;
          special_r <= 1'b0;
          state_r   <= SPECIAL;
        end
        SPECIAL: begin
          if (spec_hit_s) begin
            z_r       <= spec_z_s;
            special_r <= 1'b1;
            state_r   <= PACK;
          end else begin
            state_r   <= ALIGN;
          end
        end
        ALIGN: begin
          // afterwards a_exp_r holds the common (larger) exponent
          if (a_big_s) begin
            b_man_r <= aligned_s;
            b_exp_r <= a_exp_r;
          end else begin
            a_man_r <= aligned_s;
            a_exp_r <= b_exp_r;
          end
          state_r <= ADD;
        end
        ADD: begin
          z_man_r  <= sum_s;
          z_sign_r <= sum_sign_s;
          z_exp_r  <= a_exp_r;
          state_r  <= add_next_s;
        end
        NORM: begin
          z_man_r <= norm_man_s;
          z_exp_r <= norm_exp_s;
          state_r <= norm_done_s ? ROUND : NORM;
        end
        ROUND: begin
          z_exp_r <= rnd_exp_s;
          z_fin_r <= rnd_man_s;
          state_r <= PACK;
        end
        PACK: begin
          if (!special_r) begin
            z_r <= pack_s;
          end
          state_r <= PUT_Z;
        end
        PUT_Z: begin
          output_z     <= z_r;
          output_z_stb <= 1'b1;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state_r      <= GET_A;
          end
        end
        default: begin
          state_r <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub.sv
// tb_fp_addsub: scoreboard bench for fp_addsub, single precision plus a
// half-precision instance (EXP_W=5, MAN_W=10).
module tb_fp_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack, input_op;
  logic        output_z_stb, output_z_ack;
  logic [15:0] h_a, h_b, h_z;
  logic        h_a_stb, h_a_ack, h_b_stb, h_b_ack, h_op, h_z_stb, h_z_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_h_q[$];

  localparam int LAT_MIN = 7;
  localparam int LAT_MAX = 23 + 10;
  localparam int H_LAT_MAX = 10 + 10;

  always #5 clk = ~clk;

  fp_addsub u_dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_op(input_op), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  fp_addsub #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk(clk), .rst(rst),
    .input_a(h_a), .input_a_stb(h_a_stb), .input_a_ack(h_a_ack),
    .input_b(h_b), .input_op(h_op), .input_b_stb(h_b_stb), .input_b_ack(h_b_ack),
    .output_z(h_z), .output_z_stb(h_z_stb), .output_z_ack(h_z_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic send_ab(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op);
    int n;
    input_a = a; input_a_stb = 1'b1; n = 0;
    while (!input_a_ack && n < 20) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_a_ack", tag), 64'(input_a_ack), 64'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    check_eq($sformatf("%s_a_drop", tag), 64'(input_a_ack), 64'd0);
    input_b = b; input_op = op; input_b_stb = 1'b1; n = 0;
    while (!input_b_ack && n < 20) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_b_ack", tag), 64'(input_b_ack), 64'd1);
    @(posedge clk); #1;
    input_b_stb = 1'b0;
    check_eq($sformatf("%s_b_drop", tag), 64'(input_b_ack), 64'd0);
  endtask

  // lat_exp = 0 means "general case": latency must lie in [LAT_MIN, LAT_MAX]
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] z_want, input int lat_exp, input int hold);
    int n;
    logic [31:0] z_ref;
    exp_q.push_back(z_want);
    send_ab(tag, a, b, op);
    n = 0;
    while (!output_z_stb && n < 60) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_stb", tag), 64'(output_z_stb), 64'd1);
    z_ref = exp_q.pop_front();
    check_eq($sformatf("%s_z", tag), 64'(output_z), 64'(z_ref));
    if (lat_exp != 0) begin
      check_eq($sformatf("%s_lat", tag), 64'(n), 64'(lat_exp));
    end else begin
      check_eq($sformatf("%s_lat_range(%0d)", tag, n), 64'(n >= LAT_MIN && n <= LAT_MAX), 64'd1);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("%s_hold_stb%0d", tag, i), 64'(output_z_stb), 64'd1);
      check_eq($sformatf("%s_hold_z%0d", tag, i), 64'(output_z), 64'(z_ref));
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check_eq($sformatf("%s_stb_drop", tag), 64'(output_z_stb), 64'd0);
  endtask

  task automatic run_half(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [15:0] z_want, input int lat_exp);
    int n;
    logic [15:0] z_ref;
    exp_h_q.push_back(z_want);
    h_a = a; h_a_stb = 1'b1; n = 0;
    while (!h_a_ack && n < 20) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_a_ack", tag), 64'(h_a_ack), 64'd1);
    @(posedge clk); #1;
    h_a_stb = 1'b0;
    h_b = b; h_op = op; h_b_stb = 1'b1; n = 0;
    while (!h_b_ack && n < 20) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_b_ack", tag), 64'(h_b_ack), 64'd1);
    @(posedge clk); #1;
    h_b_stb = 1'b0;
    n = 0;
    while (!h_z_stb && n < 40) begin @(posedge clk); #1; n++; end
    check_eq($sformatf("%s_stb", tag), 64'(h_z_stb), 64'd1);
    z_ref = exp_h_q.pop_front();
    check_eq($sformatf("%s_z", tag), 64'(h_z), 64'(z_ref));
    if (lat_exp != 0) begin
      check_eq($sformatf("%s_lat", tag), 64'(n), 64'(lat_exp));
    end else begin
      check_eq($sformatf("%s_lat_range(%0d)", tag, n), 64'(n >= LAT_MIN && n <= H_LAT_MAX), 64'd1);
    end
    h_z_ack = 1'b1;
    @(posedge clk); #1;
    h_z_ack = 1'b0;
  endtask

  // 1.0 - (1 - 2^-24) needs 24 left shifts, so the FSM sits in NORM for a while
  task automatic reset_in_norm();
    send_ab("rst_norm", 32'h3F800000, 32'h3F7FFFFF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_norm_a_ack", 64'(input_a_ack), 64'd0);
    check_eq("rst_norm_b_ack", 64'(input_b_ack), 64'd0);
    check_eq("rst_norm_stb", 64'(output_z_stb), 64'd0);
    check_eq("rst_norm_z", 64'(output_z), 64'd0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("rst_norm_no_out%0d", i), 64'(output_z_stb), 64'd0);
    end
    check_eq("rst_norm_a_ack_back", 64'(input_a_ack), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    input_a = 32'd0; input_b = 32'd0; input_op = 1'b0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    h_a = 16'd0; h_b = 16'd0; h_op = 1'b0;
    h_a_stb = 1'b0; h_b_stb = 1'b0; h_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_a_ack", 64'(input_a_ack), 64'd0);
    check_eq("reset_b_ack", 64'(input_b_ack), 64'd0);
    check_eq("reset_stb", 64'(output_z_stb), 64'd0);
    check_eq("reset_z", 64'(output_z), 64'd0);
    check_eq("reset_h_stb", 64'(h_z_stb), 64'd0);
    rst = 1'b0;

    run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 5);
    run_op("cancel",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 0, 0);
    run_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4, 0);
    run_op("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4, 0);
    run_op("neg_zeros",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4, 0);
    run_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4, 0);
    run_op("one_m_ninf",  32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4, 0);
    run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 0, 0);
    run_op("denorm_add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 0, 0);
    run_op("norm_to_den", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 0, 0);
    run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 0, 0);
    run_op("tie_odd_up",  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 0, 0);
    run_op("neg_result",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 0, 0);
    run_op("deep_norm",   32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 31, 0);

    reset_in_norm();
    run_op("add_after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 7, 0);

    run_half("h_add_1_2",   16'h3C00, 16'h4000, 1'b0, 16'h4200, 7);
    run_half("h_inf_m_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
